vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port framebuffer RAM between two requesters:
  - the VGA scanout reader (read-only, latency-critical);
  - the CPU load/store port (read/write).
- Sits between the cpu core datapath, the VGA timing/pixel path and the framebuffer RAM, all on clk_50Mhz.
- Fixed priority to VGA, with a starvation guard that forces a CPU grant after a bounded wait.
- Read data is returned to the owner with a fixed latency.

Parameters:
- ADDR_W, 16, framebuffer word-address width.
- DATA_W, 8, framebuffer data width (one pixel).
- RD_LAT, 1, RAM read latency in cycles (1..4).
- STARVE_MAX, 4, consecutive denied CPU cycles before the CPU is forced to win (1..255).

Ports:
- clk_50Mhz  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- vga_req  in  1  VGA read request.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA access accepted this cycle.
- vga_rdata  out  DATA_W  VGA read data.
- vga_rvalid  out  1  vga_rdata valid, one-cycle pulse.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the address cycle.

Behaviour:
- Handshake:
  - Requester holds req/addr/we/wdata stable until it samples gnt=1 on a rising edge.
  - gnt is combinational from req and internal state: at most one of vga_gnt/cpu_gnt is high per cycle.
  - Exactly one RAM access per granted cycle.
  - Back-to-back grants to the same requester are allowed every cycle.
- Arbitration in cycle N:
  - If cpu_req and starve_cnt==STARVE_MAX: CPU wins.
  - Else if vga_req: VGA wins.
  - Else if cpu_req: CPU wins.
  - Else no grant.
- RAM outputs (combinational):
  - mem_addr = winner's address; when idle it holds the last granted address (register).
  - mem_we = cpu_gnt & cpu_we.
  - mem_wdata = cpu_wdata.
- starve_cnt (8-bit register):
  - Increments on each cycle with cpu_req=1 and cpu_gnt=0, saturating at STARVE_MAX.
  - Clears when cpu_gnt=1 or cpu_req=0.
- Read return:
  - A RD_LAT-deep tag shift register carries {valid, owner} for each granted read; writes push valid=0.
  - When a tag exits: the owner's rvalid=1 for one cycle and its rdata = mem_rdata, registered.
  - The non-owner's rdata holds its previous value.
- Latency: the rvalid edge occurs RD_LAT+1 rising edges after the gnt edge. Full throughput, one read in flight per stage.
- Simultaneous requests: VGA wins unless the starvation guard fires. The CPU sees at most STARVE_MAX denied cycles, then a guaranteed grant.
- Reset (rst=0 sampled on an edge):
  - Registered outputs go to zero: rvalid=0, rdata=0, mem_addr=0, starve_cnt=0.
  - Tag pipeline cleared, so in-flight reads are dropped with no rvalid.
  - While rst=0: vga_gnt=cpu_gnt=0 and mem_we=0, regardless of requests.
- Reset mid-transfer: a request pending during reset is regranted normally after rst returns to 1; requesters must re-present it.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds outputs stat_vga_grants[31:0], stat_cpu_grants[31:0] and stat_cpu_stall[31:0]:
  - Each is a free-running, wrap-around counter of vga_gnt cycles, cpu_gnt cycles, and cycles with cpu_req & !cpu_gnt respectively.
  - All are cleared by reset.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package vram_arb_pkg holds:
  - typedef enum logic {OWN_VGA, OWN_CPU} owner_t;
  - typedef struct packed {logic valid; owner_t owner;} rd_tag_t;
  - localparam defaults for ADDR_W/DATA_W.
- One sub-module, vram_arb_tagpipe: parameterised RD_LAT-deep rd_tag_t shift register with synchronous active-low clear.

Test Plan (STARVE_MAX=4, RD_LAT=1):
- Reset: hold rst=0 with both req=1 → vga_gnt=cpu_gnt=0, mem_we=0, rvalid=0. Release → vga_gnt=1 on the next cycle.
- VGA-only reads at addr 0x0010..0x0013, RAM preloaded 0xA0..0xA3 → vga_gnt every cycle; vga_rvalid 2 edges after each grant with 0xA0..0xA3 in order; cpu_rvalid stays 0.
- CPU write 0x5A to 0x1234 then read 0x1234 → mem_we=1 only in the write cycle; no rvalid for the write; cpu_rvalid with cpu_rdata=0x5A.
- Starvation: vga_req and cpu_req held high continuously → 4 VGA grants, then 1 CPU grant, repeating in a 5-cycle pattern.
- Reset mid-flight: CPU read granted, rst=0 on the next edge → no cpu_rvalid; after release the CPU re-requests and completes normally.
- VRAM_ARB_STATS_EN: run the starvation test for 50 cycles → stat_vga_grants=40, stat_cpu_grants=10, stat_cpu_stall=40.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter and its read-tag pipeline.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Which requester a read in flight belongs to
  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  // One entry of the read-return pipeline; writes travel as valid=0
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/vram_arb_tagpipe.sv
// Fixed-depth shift register of read tags. It mirrors the RAM read latency so
// each tag leaves the pipe in the same cycle its read data leaves the RAM.
// Synchronous active-low clear drops every read in flight.
module vram_arb_tagpipe
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk_50Mhz,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_reg [DEPTH];

  // Shift tags one stage per cycle; clear all stages while reset is low
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing the single-port framebuffer RAM between VGA scanout (read-only,
// priority) and the CPU load/store port. A starvation counter forces a CPU grant
// after STARVE_MAX consecutive denied cycles. Read data returns RD_LAT+1 cycles
// after the grant, registered, to whichever requester issued the read.
// Optional macro VRAM_ARB_STATS_EN adds free-running grant/stall counters.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_50Mhz,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_vga_grants,
  output logic [31:0]       stat_cpu_grants,
  output logic [31:0]       stat_cpu_stall
`endif
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_cnt_reg;
  logic [7:0]        starve_cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              cpu_force;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic              vga_rvalid_reg;
  logic              cpu_rvalid_reg;
  logic [DATA_W-1:0] vga_rdata_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;

  // Grant: starvation guard first, then VGA priority, then CPU; nothing in reset
  always_comb begin
    vga_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    cpu_force = cpu_req && (starve_cnt_reg == STARVE_LIM);
    if (rst) begin
      if (cpu_force) begin
        cpu_gnt = 1'b1;
      end else if (vga_req) begin
        vga_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // Count consecutive denied CPU cycles, saturating at the guard threshold
  always_comb begin
    starve_cnt_next = 8'd0;
    if (cpu_req && !cpu_gnt) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                       : starve_cnt_reg + 8'd1;
    end
  end

  // RAM address follows the winner; idle cycles replay the last granted address
  always_comb begin
    mem_addr = addr_reg;
    if (vga_gnt) begin
      mem_addr = vga_addr;
    end else if (cpu_gnt) begin
      mem_addr = cpu_addr;
    end
  end

  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_wdata = cpu_wdata;

  // Starvation counter and held address
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      addr_reg       <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      addr_reg       <= mem_addr;
    end
  end

  // Tag for this cycle's access: reads are valid, writes and idle cycles are not
  always_comb begin
    tag_in.valid = vga_gnt | (cpu_gnt & ~cpu_we);
    tag_in.owner = cpu_gnt ? OWN_CPU : OWN_VGA;
  end

  vram_arb_tagpipe #(
    .DEPTH (RD_LAT)
  ) u_tagpipe (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out)
  );

  // Capture RAM data for the owner of the exiting tag; the other side holds
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      vga_rvalid_reg <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      vga_rdata_reg  <= '0;
      cpu_rdata_reg  <= '0;
    end else begin
      vga_rvalid_reg <= tag_out.valid && (tag_out.owner == OWN_VGA);
      cpu_rvalid_reg <= tag_out.valid && (tag_out.owner == OWN_CPU);
      if (tag_out.valid && (tag_out.owner == OWN_VGA)) begin
        vga_rdata_reg <= mem_rdata;
      end
      if (tag_out.valid && (tag_out.owner == OWN_CPU)) begin
        cpu_rdata_reg <= mem_rdata;
      end
    end
  end

  assign vga_rvalid = vga_rvalid_reg;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign vga_rdata  = vga_rdata_reg;
  assign cpu_rdata  = cpu_rdata_reg;

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] stat_vga_reg;
  logic [31:0] stat_cpu_reg;
  logic [31:0] stat_stall_reg;

  // Wrap-around activity counters
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      stat_vga_reg   <= '0;
      stat_cpu_reg   <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (vga_gnt) stat_vga_reg <= stat_vga_reg + 32'd1;
      if (cpu_gnt) stat_cpu_reg <= stat_cpu_reg + 32'd1;
      if (cpu_req && !cpu_gnt) stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_vga_grants = stat_vga_reg;
  assign stat_cpu_grants = stat_cpu_reg;
  assign stat_cpu_stall  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter (STARVE_MAX=4, RD_LAT=1).
// Build with VRAM_ARB_STATS_EN to also check the statistics counters.
module tb_vram_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic              clk_50Mhz = 1'b0;
  logic              rst;
  logic              vga_req, vga_gnt, vga_rvalid;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [31:0]       stat_vga_grants, stat_cpu_grants, stat_cpu_stall;
`endif

  always #10 clk_50Mhz = ~clk_50Mhz;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_gnt   (vga_gnt),
    .vga_rdata (vga_rdata),
    .vga_rvalid(vga_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_vga_grants(stat_vga_grants),
    .stat_cpu_grants(stat_cpu_grants),
    .stat_cpu_stall (stat_cpu_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_50Mhz) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    if (i >= 16 && i <= 19) return 8'(160 + i - 16);
    return 8'(i * 7 + 3);
  endfunction

  // Behavioural single-port RAM with RD_LAT-cycle read latency
  logic [DATA_W-1:0] ram [0:65535];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk_50Mhz) begin
    if (cyc == 0) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
    end else if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard entries: cycle the data must appear and its value
  typedef struct {
    int          due;
    logic [7:0]  data;
    logic [15:0] addr;
  } exp_t;
  exp_t vga_q[$];
  exp_t cpu_q[$];

  // Reference model: arbitration rules, memory contents, expected returns
  logic        m_vga_gnt = 1'b0;
  logic        m_cpu_gnt = 1'b0;
  logic        armed     = 1'b0;
  int          denied    = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  ref_mem [0:65535];

  initial begin
    logic e_vga, e_cpu;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(negedge clk_50Mhz);
      e_vga = 1'b0;
      e_cpu = 1'b0;
      if (rst) begin
        if (cpu_req && denied == STARVE_MAX) e_cpu = 1'b1;
        else if (vga_req)                    e_vga = 1'b1;
        else if (cpu_req)                    e_cpu = 1'b1;
      end
      if (armed) begin
        chk("vga_gnt", 32'(vga_gnt), 32'(e_vga));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
        chk("mem_we", 32'(mem_we), 32'(e_cpu & cpu_we));
        if (e_vga)      last_addr = vga_addr;
        else if (e_cpu) last_addr = cpu_addr;
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        if (e_cpu && cpu_we) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
          ref_mem[cpu_addr] = cpu_wdata;
          $display("cycle %0d: cpu write %h <= %h", cyc, cpu_addr, cpu_wdata);
        end
        if (e_vga) begin
          vga_q.push_back('{cyc + RD_LAT + 1, ref_mem[vga_addr], vga_addr});
          $display("cycle %0d: vga read %h granted", cyc, vga_addr);
        end
        if (e_cpu && !cpu_we) begin
          cpu_q.push_back('{cyc + RD_LAT + 1, ref_mem[cpu_addr], cpu_addr});
          $display("cycle %0d: cpu read %h granted", cyc, cpu_addr);
        end
      end
      if (!rst) begin
        denied    = 0;
        last_addr = '0;
        armed     = 1'b1;
        while (vga_q.size() > 0 && vga_q[$].due > cyc) void'(vga_q.pop_back());
        while (cpu_q.size() > 0 && cpu_q[$].due > cyc) void'(cpu_q.pop_back());
      end else if (cpu_req && !e_cpu) begin
        denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
      end else begin
        denied = 0;
      end
      m_vga_gnt = e_vga;
      m_cpu_gnt = e_cpu;
    end
  end

  // Monitor: pop and compare whenever a read return is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50Mhz);
      if (armed) begin
        if (vga_rvalid === 1'b1) begin
          if (vga_q.size() == 0 || vga_q[0].due != cyc) begin
            chk("vga_rvalid_unexpected", 32'(vga_rvalid), 32'd0);
          end else begin
            e = vga_q.pop_front();
            chk("vga_rdata", 32'(vga_rdata), 32'(e.data));
            $display("cycle %0d: vga data %h from %h", cyc, vga_rdata, e.addr);
          end
        end else if (vga_q.size() > 0 && vga_q[0].due == cyc) begin
          e = vga_q.pop_front();
          chk("vga_rvalid_missing", 32'(vga_rvalid), 32'd1);
        end else begin
          chk("vga_rvalid_idle", 32'(vga_rvalid), 32'd0);
        end
        if (cpu_rvalid === 1'b1) begin
          if (cpu_q.size() == 0 || cpu_q[0].due != cyc) begin
            chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
          end else begin
            e = cpu_q.pop_front();
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            $display("cycle %0d: cpu data %h from %h", cyc, cpu_rdata, e.addr);
          end
        end else if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid_missing", 32'(cpu_rvalid), 32'd1);
        end else begin
          chk("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic do_vga(input logic [15:0] a);
    int budget = 0;
    vga_req  = 1'b1;
    vga_addr = a;
    do begin
      cycle();
      budget++;
    end while (!m_vga_gnt && budget < 20);
    chk("vga_grant_wait", 32'(m_vga_gnt), 32'd1);
    vga_req = 1'b0;
  endtask

  task automatic do_cpu(input logic we, input logic [15:0] a, input logic [7:0] d);
    int budget = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    do begin
      cycle();
      budget++;
    end while (!m_cpu_gnt && budget < 20);
    chk("cpu_grant_wait", 32'(m_cpu_gnt), 32'd1);
    cpu_req = 1'b0;
  endtask

  // Stimulus
  initial begin
    // Reset with both requesters asking; nothing may be granted or written
    rst = 1'b0;
    vga_req = 1'b1; vga_addr = 16'h0010;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h77;
    repeat (3) cycle();
    @(negedge clk_50Mhz);
    chk("reset_vga_rdata", 32'(vga_rdata), 32'd0);
    chk("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    cycle();
    rst = 1'b1;
    cpu_req = 1'b0;

    // VGA-only back-to-back reads of the preloaded pixels
    for (int i = 0; i < 4; i++) do_vga(16'h0010 + 16'(i));
    repeat (3) cycle();

    // CPU write then read-back of the same word
    do_cpu(1'b1, 16'h1234, 8'h5A);
    do_cpu(1'b0, 16'h1234, 8'h00);
    repeat (4) cycle();
    chk("cpu_rdata_hold", 32'(cpu_rdata), 32'h5A);

    // Starvation: both held high for 50 cycles from a clean reset
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    vga_req = 1'b1; vga_addr = 16'(16'h0200 + $urandom_range(0, 255));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(16'h0300 + $urandom_range(0, 255));
    repeat (50) begin
      cycle();
      if (m_vga_gnt) vga_addr = 16'(16'h0200 + $urandom_range(0, 255));
      if (m_cpu_gnt) cpu_addr = 16'(16'h0300 + $urandom_range(0, 255));
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
`ifdef VRAM_ARB_STATS_EN
    @(negedge clk_50Mhz);
    chk("stat_vga_grants", stat_vga_grants, 32'd40);
    chk("stat_cpu_grants", stat_cpu_grants, 32'd10);
    chk("stat_cpu_stall", stat_cpu_stall, 32'd40);
`endif
    repeat (4) cycle();

    // Reset one cycle after a CPU read grant drops the read; re-request completes
    do_cpu(1'b0, 16'h0042, 8'h00);
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    do_cpu(1'b0, 16'h0042, 8'h00);
    repeat (4) cycle();

    // Random traffic over a small window so reads hit recent writes
    for (int n = 0; n < 400; n++) begin
      if (!vga_req || m_vga_gnt) begin
        vga_req  = 1'($urandom_range(0, 1));
        vga_addr = 16'(16'h0040 + $urandom_range(0, 15));
      end
      if (!cpu_req || m_cpu_gnt) begin
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'(16'h0040 + $urandom_range(0, 15));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      cycle();
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
    repeat (6) cycle();
    chk("vga_queue_drained", 32'(vga_q.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
